// File: rtl/length_sequencer.sv
// Issue/accumulate sequencer for a ribbon-length pipeline: registers accepted box
// dimensions onto the pipe interface and sums the returned per-box lengths.
module length_sequencer #(
  parameter int SIZE_WIDTH   = 8,
  parameter int LENGTH_WIDTH = 16,
  parameter int TOTAL_WIDTH  = 32,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIZE_WIDTH-1:0]   in_length,
  input  logic [SIZE_WIDTH-1:0]   in_width,
  input  logic [SIZE_WIDTH-1:0]   in_height,
  input  logic                    in_last,
  output logic                    pipe_size_valid,
  output logic [SIZE_WIDTH-1:0]   pipe_length,
  output logic [SIZE_WIDTH-1:0]   pipe_width,
  output logic [SIZE_WIDTH-1:0]   pipe_height,
  input  logic                    pipe_result_valid,
  input  logic [LENGTH_WIDTH-1:0] pipe_result,
  input  logic                    clear,
  output logic                    total_valid,
  output logic [TOTAL_WIDTH-1:0]  total,
  output logic [15:0]             box_count,
  output logic                    error
);

  localparam int CNT_WIDTH = $clog2(PIPE_LATENCY + 2);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] inflight;
  logic                 accept;
  logic                 result_ok;
  logic                 result_bad;
  logic                 restart;

  // ready_q keeps in_ready low during reset and until the first edge after release.
  assign in_ready   = ready_q && (state == ST_RUN);
  assign accept     = in_valid && in_ready;
  assign result_ok  = pipe_result_valid && (inflight != '0) && (state != ST_DONE);
  assign result_bad = pipe_result_valid && !result_ok;
  assign restart    = clear && (state == ST_DONE);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (accept && in_last) state_next = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && !pipe_size_valid && !pipe_result_valid)
                  state_next = ST_DONE;
      ST_DONE:  if (clear) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      ready_q     <= 1'b0;
      total_valid <= 1'b0;
    end else begin
      state       <= state_next;
      ready_q     <= 1'b1;
      total_valid <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_size_valid <= 1'b0;
      pipe_length     <= '0;
      pipe_width      <= '0;
      pipe_height     <= '0;
    end else begin
      pipe_size_valid <= accept;
      if (accept) begin
        pipe_length <= in_length;
        pipe_width  <= in_width;
        pipe_height <= in_height;
      end
    end
  end

  // Simultaneous issue and accepted result leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({pipe_size_valid, result_ok})
        2'b10:   inflight <= inflight + CNT_WIDTH'(1);
        2'b01:   inflight <= inflight - CNT_WIDTH'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Truncating the result before the add gives the same modulo-2^TOTAL_WIDTH sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total     <= '0;
      box_count <= '0;
      error     <= 1'b0;
    end else begin
      if (restart) begin
        total     <= '0;
        box_count <= '0;
      end else if (result_ok) begin
        total     <= total + TOTAL_WIDTH'(pipe_result);
        box_count <= box_count + 16'd1;
      end
      if (result_bad) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_length_sequencer.sv
// Self-checking bench: a 4-cycle queue-based ribbon pipeline model feeds two DUTs
// (32-bit and 8-bit totals) driven by directed and randomized jobs.
module tb_length_sequencer;

  localparam int PIPE_LATENCY = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_length, in_width, in_height;
  logic        in_last;
  logic        pipe_result_valid;
  logic [15:0] pipe_result;
  logic        clear;

  logic        in_ready, pipe_size_valid, total_valid, error;
  logic [7:0]  pipe_length, pipe_width, pipe_height;
  logic [31:0] total;
  logic [15:0] box_count;

  logic        in_ready8, pipe_size_valid8, total_valid8, error8;
  logic [7:0]  pipe_length8, pipe_width8, pipe_height8;
  logic [7:0]  total8;
  logic [15:0] box_count8;

  length_sequencer #(.PIPE_LATENCY(PIPE_LATENCY)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_length(in_length), .in_width(in_width), .in_height(in_height), .in_last(in_last),
    .pipe_size_valid(pipe_size_valid), .pipe_length(pipe_length), .pipe_width(pipe_width),
    .pipe_height(pipe_height), .pipe_result_valid(pipe_result_valid), .pipe_result(pipe_result),
    .clear(clear), .total_valid(total_valid), .total(total), .box_count(box_count), .error(error)
  );

  length_sequencer #(.TOTAL_WIDTH(8), .PIPE_LATENCY(PIPE_LATENCY)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_length(in_length), .in_width(in_width), .in_height(in_height), .in_last(in_last),
    .pipe_size_valid(pipe_size_valid8), .pipe_length(pipe_length8), .pipe_width(pipe_width8),
    .pipe_height(pipe_height8), .pipe_result_valid(pipe_result_valid), .pipe_result(pipe_result),
    .clear(clear), .total_valid(total_valid8), .total(total8), .box_count(box_count8), .error(error8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [7:0] l, w, h; } box_t;
  typedef struct { int due; int val; } res_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_res_cyc = 0;
  int          n_issues = 0;
  int          issue_cyc[$];
  box_t        acc_q[$];
  res_t        pq[$];
  bit          acc_prev = 0;
  bit          spur_req = 0;
  int          spur_val = 0;
  logic [23:0] last_dims = '0;
  logic [63:0] exp_sum = '0;
  int          exp_cnt = 0;
  box_t        mon_b;
  res_t        mon_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Ribbon = smallest face perimeter plus volume.
  function automatic int ribbon(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return 2 * (a + b + c - m) + a * b * c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Issue monitor plus the reference pipeline returning results PIPE_LATENCY cycles later.
  always @(negedge clk) begin
    if (rst_n) begin
      check("issue_timing", pipe_size_valid, acc_prev);
      check("issue_timing_w8", pipe_size_valid8, acc_prev);
      if (pipe_size_valid) begin
        check("issue_has_record", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          mon_b = acc_q.pop_front();
          last_dims = {mon_b.l, mon_b.w, mon_b.h};
        end
        n_issues++;
        issue_cyc.push_back(cyc);
        pq.push_back('{cyc + PIPE_LATENCY, ribbon(pipe_length, pipe_width, pipe_height)});
      end
      check("pipe_dims", {pipe_length, pipe_width, pipe_height}, last_dims);
      check("pipe_dims_w8", {pipe_length8, pipe_width8, pipe_height8}, last_dims);
      acc_prev = in_valid && in_ready;
      if (acc_prev) acc_q.push_back('{in_length, in_width, in_height});
    end else begin
      acc_prev  = 0;
      last_dims = '0;
      acc_q.delete();
    end
    pipe_result_valid = 1'b0;
    pipe_result       = '0;
    if (pq.size() != 0 && pq[0].due == cyc) begin
      mon_r = pq.pop_front();
      pipe_result_valid = 1'b1;
      pipe_result       = 16'(mon_r.val);
      last_res_cyc      = cyc;
    end else if (spur_req) begin
      pipe_result_valid = 1'b1;
      pipe_result       = 16'(spur_val);
      spur_req          = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int l, input int w, input int h, input bit last);
    in_valid  = 1'b1;
    in_length = 8'(l);
    in_width  = 8'(w);
    in_height = 8'(h);
    in_last   = last;
    @(negedge clk);
    check("in_ready_run", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_sum  = exp_sum + 64'(ribbon(l, w, h));
    exp_cnt++;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int t = 0;
    @(negedge clk);
    while (!total_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, total_valid, 1);
    check({tag, "_done_latency"}, cyc - last_res_cyc, 2);
    check({tag, "_total"}, total, exp_sum[31:0]);
    check({tag, "_count"}, box_count, exp_cnt);
    check({tag, "_total_w8"}, total8, exp_sum[7:0]);
    check({tag, "_done_w8"}, total_valid8, 1);
    check({tag, "_ready_done"}, in_ready, 0);
    step(3);
    check({tag, "_hold_valid"}, total_valid, 1);
    check({tag, "_hold_total"}, total, exp_sum[31:0]);
    check({tag, "_hold_count"}, box_count, exp_cnt);
  endtask

  task automatic new_job();
    pulse_clear();
    check("clear_valid", total_valid, 0);
    check("clear_total", total, 0);
    check("clear_count", box_count, 0);
    check("clear_ready", in_ready, 1);
    exp_sum = '0;
    exp_cnt = 0;
  endtask

  initial begin
    int n, g, i0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    in_length = '0; in_width = '0; in_height = '0;
    #2;
    check("rst_ready", in_ready, 0);
    check("rst_issue", pipe_size_valid, 0);
    check("rst_total", total, 0);
    check("rst_count", box_count, 0);
    check("rst_valid", total_valid, 0);
    check("rst_error", error, 0);
    check("rst_dims", {pipe_length, pipe_width, pipe_height}, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("ready_before_edge", in_ready, 0);
    step(1);
    check("ready_after_edge", in_ready, 1);

    // Single box 2x3x4.
    send(2, 3, 4, 1);
    finish_job("single");
    check("single_error", error, 0);

    // Back-to-back pair; clear during DRAIN is ignored.
    new_job();
    i0 = issue_cyc.size();
    send(2, 3, 4, 0);
    send(1, 1, 10, 1);
    pulse_clear();
    check("pair_consecutive", issue_cyc[i0 + 1] - issue_cyc[i0], 1);
    finish_job("pair");

    // in_last without acceptance does nothing.
    new_job();
    in_last = 1'b1;
    step(2);
    in_last = 1'b0;
    check("last_no_accept", in_ready, 1);

    // Five records with one idle cycle.
    n = n_issues;
    send(3, 4, 5, 0);
    send(6, 2, 2, 0);
    send(1, 9, 3, 0);
    step(1);
    send(7, 7, 7, 0);
    send(2, 5, 8, 1);
    finish_job("five");
    check("five_issues", n_issues - n, 5);

    // Results 200 and 100: 8-bit total wraps to 44.
    new_job();
    send(1, 2, 97, 0);
    send(1, 2, 47, 1);
    finish_job("wrap");
    check("wrap_w8_44", total8, 44);

    // Randomized jobs.
    for (int j = 0; j < 4; j++) begin
      new_job();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        g = $urandom_range(0, 2);
        step(g);
        send($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 30), k == n - 1);
      end
      finish_job("random");
      check("random_error", error, 0);
    end

    // Spurious result while idle in RUN.
    new_job();
    spur_val = 7;
    spur_req = 1;
    step(2);
    check("spur_error", error, 1);
    check("spur_error_w8", error8, 1);
    check("spur_total", total, 0);
    check("spur_count", box_count, 0);
    send(1, 1, 1, 1);
    finish_job("after_spur");

    // Result in DONE: flagged, total untouched; error survives clear.
    spur_val = 9;
    spur_req = 1;
    step(2);
    check("done_res_total", total, 5);
    check("done_res_count", box_count, 1);
    new_job();
    check("error_sticky", error, 1);

    // Reset during DRAIN with two in flight.
    send(2, 3, 4, 0);
    send(1, 1, 10, 1);
    step(1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_issue", pipe_size_valid, 0);
    check("mid_rst_total", total, 0);
    check("mid_rst_count", box_count, 0);
    check("mid_rst_valid", total_valid, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_dims", {pipe_length, pipe_width, pipe_height}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(6);
    check("stale_error", error, 1);
    check("stale_total", total, 0);
    check("stale_count", box_count, 0);
    exp_sum = '0;
    exp_cnt = 0;
    pulse_clear();
    send(1, 1, 1, 1);
    finish_job("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
